// File: rtl/dig_sel18_seq_pkg.sv
// Shared DAC definitions for the 18-element DEM selector path.
// Element count, MODE bit positions, FSM encoding and code clamp.
package dig_sel18_seq_pkg;

  localparam int N_ELEM   = 18;
  localparam int MODE_ISI = 0;
  localparam int MODE_MIS = 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_SEL  = 2'd2;
  localparam logic [1:0] ST_CAP  = 2'd3;

  function automatic logic is_clip(
    input logic signed [5:0] din
  );
    return (din < 0) || (din > N_ELEM);
  endfunction

  function automatic logic [4:0] clamp_code(
    input logic signed [5:0] din
  );
    logic [4:0] r;
    if (din < 0)
      r = 5'd0;
    else if (din > N_ELEM)
      r = 5'(N_ELEM);
    else
      r = din[4:0];
    return r;
  endfunction

endpackage

// File: rtl/dig_sel18_seq_popcnt.sv
// dig_popcnt18: combinational 18-bit population count.
// Ports: i_vec (element vector) -> o_cnt (number of ones, 0..18).
module dig_popcnt18
  import dig_sel18_seq_pkg::*;
(
  input  logic [N_ELEM-1:0] i_vec,
  output logic [4:0]        o_cnt
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < N_ELEM; i++)
      o_cnt = o_cnt + 5'(i_vec[i]);
  end

endmodule

// File: rtl/dig_sel18_seq.sv
// Per-sample sequencer for the 18-element DEM selector path.
// Ports: CLK/RSTn, DIN valid/ready + MODE, sorter start/done,
//   V/GAMA/BETA/ISI_SEL/MIS_SEL to selector, SV_IN -> SV_OUT,
//   SV_VALID, CLIP and sticky ERR.
module dig_sel18_seq
  import dig_sel18_seq_pkg::*;
#(
  parameter int SETTLE   = 1,
  parameter int SORT_TMO = 15
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 DIN_VALID,
  output logic                 DIN_READY,
  input  logic signed [5:0]    DIN,
  input  logic [1:0]           MODE,
  output logic                 SORT_START,
  input  logic                 SORT_DONE,
  output logic signed [5:0]    V,
  output logic [4:0]           GAMA,
  output logic [4:0]           BETA,
  output logic                 ISI_SEL,
  output logic                 MIS_SEL,
  input  logic [N_ELEM-1:0]    SV_IN,
  output logic [N_ELEM-1:0]    SV_OUT,
  output logic                 SV_VALID,
  output logic                 CLIP,
  output logic                 ERR
);

  localparam logic [5:0] TMO = 6'(SORT_TMO);
  localparam logic [2:0] STL = 3'(SETTLE);

  logic [1:0]        r_state;
  logic [5:0]        r_tmr;
  logic [2:0]        r_settle;
  logic [4:0]        r_n;
  logic [4:0]        r_gama;
  logic [4:0]        r_beta;
  logic [4:0]        r_p;
  logic              r_isi;
  logic              r_mis;
  logic              r_start;
  logic              r_svv;
  logic              r_err;
  logic [N_ELEM-1:0] r_sv;

  logic              w_accept;
  logic [4:0]        w_n;
  logic [4:0]        w_gama;
  logic [4:0]        w_beta;
  logic [4:0]        w_pc;

  dig_popcnt18 u_popcnt (
    .i_vec (SV_IN),
    .o_cnt (w_pc)
  );

  assign w_accept = DIN_VALID && (r_state == ST_IDLE);
  assign w_n      = clamp_code(DIN);

  // Reuse previously-on elements first; new ones only for the excess.
  always_comb begin
    if (w_n >= r_p) begin
      w_beta = r_p;
      w_gama = w_n - r_p;
    end else begin
      w_beta = w_n;
      w_gama = 5'd0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= ST_IDLE;
      r_tmr    <= '0;
      r_settle <= '0;
      r_n      <= '0;
      r_gama   <= '0;
      r_beta   <= '0;
      r_p      <= '0;
      r_isi    <= 1'b0;
      r_mis    <= 1'b0;
      r_start  <= 1'b0;
      r_svv    <= 1'b0;
      r_err    <= 1'b0;
      r_sv     <= '0;
    end else begin
      r_start <= 1'b0;
      r_svv   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_n    <= w_n;
            r_gama <= w_gama;
            r_beta <= w_beta;
            r_isi  <= MODE[MODE_ISI];
            r_mis  <= MODE[MODE_MIS];
            if (MODE == 2'b11) begin
              r_settle <= 3'd1;
              r_state  <= ST_SEL;
            end else begin
              r_start <= 1'b1;
              r_tmr   <= 6'd1;
              r_state <= ST_SORT;
            end
          end
        end
        ST_SORT: begin
          if (SORT_DONE) begin
            r_settle <= 3'd1;
            r_state  <= ST_SEL;
          end else if (r_tmr >= TMO) begin
            // Unsorted sample: fall back to plain selection.
            r_err    <= 1'b1;
            r_isi    <= 1'b1;
            r_settle <= 3'd1;
            r_state  <= ST_SEL;
          end else begin
            r_tmr <= r_tmr + 6'd1;
          end
        end
        ST_SEL: begin
          if (r_settle >= STL) begin
            // New enables and SV_VALID appear together in CAP.
            r_sv    <= SV_IN;
            r_p     <= w_pc;
            r_svv   <= 1'b1;
            r_state <= ST_CAP;
          end else begin
            r_settle <= r_settle + 3'd1;
          end
        end
        ST_CAP: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DIN_READY  = (r_state == ST_IDLE);
  assign CLIP       = w_accept && is_clip(DIN);
  assign SORT_START = r_start;
  assign V          = {1'b0, r_n};
  assign GAMA       = r_gama;
  assign BETA       = r_beta;
  assign ISI_SEL    = r_isi;
  assign MIS_SEL    = r_mis;
  assign SV_OUT     = r_sv;
  assign SV_VALID   = r_svv;
  assign ERR        = r_err;

endmodule

// File: tb/tb_dig_sel18_seq.sv
// Directed vector bench for dig_sel18_seq.
// Table of samples plus hand sequences for reset-in-flight.
module tb_dig_sel18_seq;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              DIN_VALID = 1'b0;
  logic              DIN_READY;
  logic signed [5:0] DIN = '0;
  logic [1:0]        MODE = '0;
  logic              SORT_START;
  logic              SORT_DONE = 1'b0;
  logic [5:0]        V;
  logic [4:0]        GAMA;
  logic [4:0]        BETA;
  logic              ISI_SEL;
  logic              MIS_SEL;
  logic [17:0]       SV_IN = '0;
  logic [17:0]       SV_OUT;
  logic              SV_VALID;
  logic              CLIP;
  logic              ERR;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dig_sel18_seq #(.SETTLE(1), .SORT_TMO(15)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .DIN_VALID  (DIN_VALID),
    .DIN_READY  (DIN_READY),
    .DIN        (DIN),
    .MODE       (MODE),
    .SORT_START (SORT_START),
    .SORT_DONE  (SORT_DONE),
    .V          (V),
    .GAMA       (GAMA),
    .BETA       (BETA),
    .ISI_SEL    (ISI_SEL),
    .MIS_SEL    (MIS_SEL),
    .SV_IN      (SV_IN),
    .SV_OUT     (SV_OUT),
    .SV_VALID   (SV_VALID),
    .CLIP       (CLIP),
    .ERR        (ERR)
  );

  typedef struct {
    logic signed [5:0] din;
    logic [1:0]        mode;
    int                k;
    logic [17:0]       sv;
    logic [5:0]        v;
    logic [4:0]        g;
    logic [4:0]        b;
    logic              clip;
    logic              isi;
    logic              mis;
    logic              err;
    int                cyc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // k: SORT_DONE rises k cycles after SORT_START (-1 = never).
  // cyc: cycle of SV_VALID counted from the accept cycle.
  task automatic run_vec(input int idx, input vec_t t);
    int  st_cnt;
    bit  seen;
    string p;
    p = $sformatf("v%0d_", idx);
    st_cnt = 0;
    seen = 0;
    chk({p, "ready"}, 32'(DIN_READY), 32'd1);
    DIN = t.din;
    MODE = t.mode;
    SV_IN = t.sv;
    DIN_VALID = 1'b1;
    #1;
    chk({p, "clip"}, 32'(CLIP), 32'(t.clip));
    @(negedge CLK);
    DIN_VALID = 1'b0;
    DIN = '0;
    chk({p, "v"}, 32'(V), 32'(t.v));
    chk({p, "gama"}, 32'(GAMA), 32'(t.g));
    chk({p, "beta"}, 32'(BETA), 32'(t.b));
    chk({p, "mis"}, 32'(MIS_SEL), 32'(t.mis));
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (c > 1) @(negedge CLK);
      st_cnt += int'(SORT_START);
      SORT_DONE = (t.k >= 0) && (c >= 1 + t.k);
      if (SV_VALID) begin
        seen = 1;
        chk({p, "lat"}, 32'(c), 32'(t.cyc));
        chk({p, "sv_out"}, 32'(SV_OUT), 32'(t.sv));
        chk({p, "isi"}, 32'(ISI_SEL), 32'(t.isi));
        chk({p, "err"}, 32'(ERR), 32'(t.err));
      end
    end
    SORT_DONE = 1'b0;
    chk({p, "sv_valid_seen"}, 32'(seen), 32'd1);
    chk({p, "starts"}, 32'(st_cnt),
        (t.mode == 2'b11) ? 32'd0 : 32'd1);
    @(negedge CLK);
    chk({p, "ready_back"}, 32'(DIN_READY), 32'd1);
    chk({p, "sv_valid_pulse"}, 32'(SV_VALID), 32'd0);
  endtask

  initial begin
    //          din     md  k   sv          v   g   b   cl is ms er cyc
    tbl[0]  = '{6'sd5,  0,  3,  18'h0001F,  5,  5,  0,  0, 0, 0, 0, 6};
    tbl[1]  = '{6'sd3,  0,  0,  18'h00007,  3,  0,  3,  0, 0, 0, 0, 3};
    tbl[2]  = '{-6'sd4, 0,  1,  18'h00000,  0,  0,  0,  1, 0, 0, 0, 4};
    tbl[3]  = '{6'sd25, 0,  2,  18'h3FFFF,  18, 18, 0,  1, 0, 0, 0, 5};
    tbl[4]  = '{6'sd10, 1,  0,  18'h003FF,  10, 0,  10, 0, 1, 0, 0, 3};
    tbl[5]  = '{6'sd18, 0,  14, 18'h3FFFF,  18, 8,  10, 0, 0, 0, 0, 17};
    tbl[6]  = '{6'sd12, 2,  -1, 18'h00FFF,  12, 0,  12, 0, 1, 1, 1, 17};
    tbl[7]  = '{6'sd7,  0,  1,  18'h0007F,  7,  0,  7,  0, 0, 0, 1, 4};
    tbl[8]  = '{6'sd9,  3,  -1, 18'h001FF,  9,  2,  7,  0, 1, 1, 1, 2};
    tbl[9]  = '{6'sd0,  0,  0,  18'h00000,  0,  0,  0,  0, 0, 0, 1, 3};
    tbl[10] = '{6'sd19, 0,  0,  18'h15555,  18, 18, 0,  1, 0, 0, 1, 3};
    tbl[11] = '{6'sd6,  0,  2,  18'h0003F,  6,  6,  0,  0, 0, 0, 0, 5};

    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_ready", 32'(DIN_READY), 32'd1);
    chk("rst_sv_out", 32'(SV_OUT), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_v", 32'(V), 32'd0);
    chk("rst_gama", 32'(GAMA), 32'd0);
    chk("rst_beta", 32'(BETA), 32'd0);
    chk("rst_sv_valid", 32'(SV_VALID), 32'd0);

    for (int i = 0; i < 11; i++)
      run_vec(i, tbl[i]);

    // Reset while the bypass sample sits in SEL.
    DIN = 6'sd4;
    MODE = 2'b11;
    SV_IN = 18'h0000F;
    DIN_VALID = 1'b1;
    @(negedge CLK);
    DIN_VALID = 1'b0;
    chk("mid_busy", 32'(DIN_READY), 32'd0);
    RSTn = 1'b0;
    #1;
    chk("mid_ready", 32'(DIN_READY), 32'd1);
    chk("mid_v", 32'(V), 32'd0);
    chk("mid_gama", 32'(GAMA), 32'd0);
    chk("mid_beta", 32'(BETA), 32'd0);
    chk("mid_isi", 32'(ISI_SEL), 32'd0);
    chk("mid_mis", 32'(MIS_SEL), 32'd0);
    chk("mid_sv_out", 32'(SV_OUT), 32'd0);
    chk("mid_err", 32'(ERR), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mid_no_valid", 32'(SV_VALID), 32'd0);
    end
    RSTn = 1'b1;
    @(negedge CLK);
    chk("mid_after_sv", 32'(SV_OUT), 32'd0);
    chk("mid_after_valid", 32'(SV_VALID), 32'd0);

    run_vec(11, tbl[11]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
